// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers.
// A mult/div latches its 64-bit result on the Start edge and holds Busy for a fixed number of cycles.
// mthi/mtlo write HI/LO directly from A without going busy.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [63:0]        res_q, res_d;
  logic               wr_q, wr_d;     // result is to be committed at completion (false on divide by zero)
  logic               busy_q, busy_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;

  logic signed [63:0] sa64, sb64, smul;
  logic        [63:0] ua64, ub64, umul;
  logic signed [31:0] sa, sb, div_q, div_r;
  logic        [31:0] divu_q, divu_r;
  logic               b_zero;

  // Operand extension and products
  assign sa   = $signed(A);
  assign sb   = $signed(B);
  assign sa64 = $signed({{32{A[31]}}, A});
  assign sb64 = $signed({{32{B[31]}}, B});
  assign ua64 = {32'd0, A};
  assign ub64 = {32'd0, B};
  assign smul = sa64 * sb64;
  assign umul = ua64 * ub64;
  assign b_zero = (B == 32'd0);

  // Quotient/remainder; the one signed overflow case is pinned explicitly
  always_comb begin
    div_q  = '0;
    div_r  = '0;
    divu_q = '0;
    divu_r = '0;
    if (!b_zero) begin
      divu_q = A / B;
      divu_r = A % B;
      if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
        div_q = $signed(32'h8000_0000);
        div_r = '0;
      end else begin
        div_q = sa / sb;
        div_r = sa % sb;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Next-state, counter, result latch and HI/LO update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    wr_d    = wr_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          case (MDOp)
            OP_MULT, OP_MULTU: begin
              res_d   = (MDOp == OP_MULT) ? $unsigned(smul) : umul;
              wr_d    = 1'b1;
              cnt_d   = CNT_W'(MULT_CYCLES - 1);
              state_d = RUN;
              busy_d  = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              res_d   = (MDOp == OP_DIV) ? {$unsigned(div_r), $unsigned(div_q)} : {divu_r, divu_q};
              wr_d    = !b_zero;
              cnt_d   = CNT_W'(DIV_CYCLES - 1);
              state_d = RUN;
              busy_d  = 1'b1;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          if (wr_q) begin
            hi_d = res_q[63:32];
            lo_d = res_q[31:0];
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: timing of Busy, arithmetic results, mthi/mtlo, reset and Start filtering.
module tb_md_unit;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_checks;
  int n_fail;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .Start (Start),
    .MDOp  (MDOp),
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one Start for exactly one rising edge; returns at the following falling edge
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1;
    MDOp  = op;
    A     = a;
    B     = b;
    @(negedge clk);
    Start = 1'b0;
  endtask

  // Count consecutive falling edges with Busy high, bounded
  task automatic count_busy(output int n);
    n = 0;
    while (Busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    Start = 1'b0;
    MDOp  = 3'b000;
    A     = '0;
    B     = '0;
    @(negedge clk);
    n_checks++;
    if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: got Busy=%b HI=%h LO=%h, want 0/0/0", Busy, HI, LO);
    end
    // first edge after release must accept a Start
    reset = 1'b1;
    issue(3'b101, 32'h0000_0099, 32'h0);
    n_checks++;
    if (LO !== 32'h0000_0099 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL first_start_after_reset: got LO=%h Busy=%b, want 00000099/0", LO, Busy);
    end
  endtask

  task automatic test_mult();
    int n;
    issue(3'b000, 32'hFFFF_FFFE, 32'd3);
    A = 32'hFFFF_FFFF;   // operand changes during RUN must not matter
    B = 32'h7FFF_FFFF;
    n_checks++;
    if (HI !== 32'h0 || LO !== 32'h0000_0099) begin
      n_fail++;
      $display("FAIL mult_hold: got HI=%h LO=%h, want 00000000/00000099", HI, LO);
    end
    count_busy(n);
    n_checks++;
    if (n !== 5) begin
      n_fail++;
      $display("FAIL mult_busy_cycles: got %0d, want 5", n);
    end
    n_checks++;
    if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFA) begin
      n_fail++;
      $display("FAIL mult_result: got HI=%h LO=%h, want ffffffff/fffffffa", HI, LO);
    end
    issue(3'b001, 32'hFFFF_FFFE, 32'd3);
    count_busy(n);
    n_checks++;
    if (n !== 5 || HI !== 32'h0000_0002 || LO !== 32'hFFFF_FFFA) begin
      n_fail++;
      $display("FAIL multu_result: got n=%0d HI=%h LO=%h, want 5/00000002/fffffffa", n, HI, LO);
    end
  endtask

  task automatic test_div();
    int n;
    issue(3'b010, 32'hFFFF_FFF9, 32'd2);
    count_busy(n);
    n_checks++;
    if (n !== 10) begin
      n_fail++;
      $display("FAIL div_busy_cycles: got %0d, want 10", n);
    end
    n_checks++;
    if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD) begin
      n_fail++;
      $display("FAIL div_signed: got HI=%h LO=%h, want ffffffff/fffffffd", HI, LO);
    end
    issue(3'b011, 32'd100, 32'd7);
    count_busy(n);
    n_checks++;
    if (n !== 10 || HI !== 32'd2 || LO !== 32'd14) begin
      n_fail++;
      $display("FAIL divu_result: got n=%0d HI=%h LO=%h, want 10/00000002/0000000e", n, HI, LO);
    end
    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    count_busy(n);
    n_checks++;
    if (HI !== 32'h0 || LO !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL div_overflow: got HI=%h LO=%h, want 00000000/80000000", HI, LO);
    end
  endtask

  task automatic test_divzero();
    int n;
    issue(3'b100, 32'h0000_0011, 32'h0);
    n_checks++;
    if (Busy !== 1'b0 || HI !== 32'h0000_0011) begin
      n_fail++;
      $display("FAIL mthi: got Busy=%b HI=%h, want 0/00000011", Busy, HI);
    end
    issue(3'b101, 32'h0000_0022, 32'h0);
    issue(3'b011, 32'd5, 32'd0);
    count_busy(n);
    n_checks++;
    if (n !== 10 || HI !== 32'h0000_0011 || LO !== 32'h0000_0022) begin
      n_fail++;
      $display("FAIL divu_by_zero: got n=%0d HI=%h LO=%h, want 10/00000011/00000022", n, HI, LO);
    end
  endtask

  task automatic test_mt_ops();
    int n;
    issue(3'b101, 32'h1234_5678, 32'h0);
    n_checks++;
    if (Busy !== 1'b0 || LO !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL mtlo: got Busy=%b LO=%h, want 0/12345678", Busy, LO);
    end
    issue(3'b000, 32'd3, 32'd4);
    issue(3'b100, 32'hDEAD_BEEF, 32'h0);   // mthi during RUN
    n_checks++;
    if (HI !== 32'h0000_0011 || Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mthi_in_run: got HI=%h Busy=%b, want 00000011/1", HI, Busy);
    end
    count_busy(n);
    n_checks++;
    if (n !== 4 || HI !== 32'h0 || LO !== 32'd12) begin
      n_fail++;
      $display("FAIL mult_after_mthi: got n=%0d HI=%h LO=%h, want 4/00000000/0000000c", n, HI, LO);
    end
    issue(3'b110, 32'hAAAA_AAAA, 32'h5);   // reserved op
    n_checks++;
    if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'd12) begin
      n_fail++;
      $display("FAIL reserved_op: got Busy=%b HI=%h LO=%h, want 0/00000000/0000000c", Busy, HI, LO);
    end
  endtask

  task automatic test_reset_mid_run();
    issue(3'b100, 32'h0000_0055, 32'h0);
    issue(3'b000, 32'd5, 32'd7);           // Busy cycle 1 at this falling edge
    @(negedge clk);                          // cycle 2
    @(negedge clk);                          // cycle 3
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: got Busy=%b HI=%h LO=%h, want 0/0/0", Busy, HI, LO);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_discard: got Busy=%b HI=%h LO=%h, want 0/0/0", Busy, HI, LO);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    issue(3'b011, 32'd20, 32'd3);            // Busy sample 1
    repeat (9) @(negedge clk);               // Busy sample 10; next edge completes
    Start = 1'b1;
    MDOp  = 3'b000;
    A     = 32'd2;
    B     = 32'd3;
    @(negedge clk);
    n_checks++;
    if (Busy !== 1'b0 || HI !== 32'd2 || LO !== 32'd6) begin
      n_fail++;
      $display("FAIL start_on_completion: got Busy=%b HI=%h LO=%h, want 0/00000002/00000006", Busy, HI, LO);
    end
    A = 32'd4;
    B = 32'd5;
    @(negedge clk);
    Start = 1'b0;
    count_busy(n);
    n_checks++;
    if (n !== 5 || HI !== 32'h0 || LO !== 32'd20) begin
      n_fail++;
      $display("FAIL mult_after_div: got n=%0d HI=%h LO=%h, want 5/00000000/00000014", n, HI, LO);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_mult();
    test_div();
    test_divzero();
    test_mt_ops();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
